// File: rtl/dt_walk_engine.sv
// ---------------------------------------------------------------------------
// dt_walk_engine : table-driven decision-tree classifier, one node per clock
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dt_walk_engine #(
  parameter int IN_W      = 5,
  parameter int OUT_W     = 5,
  parameter int NODE_AW   = 4,
  parameter int MAX_DEPTH = 8,
  localparam int FSEL_W   = (IN_W > 1) ? $clog2(IN_W) : 1,
  localparam int ENT_W    = 1 + FSEL_W + 2 * NODE_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [NODE_AW-1:0] cfg_addr,
  input  logic [ENT_W-1:0]   cfg_wdata,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_err
);

  localparam int DEPTH_W  = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int N_NODES  = 2 ** NODE_AW;
  localparam logic [FSEL_W:0]    C_IN_W       = IN_W[FSEL_W:0];
  localparam logic [DEPTH_W-1:0] C_DEPTH_LAST = DEPTH_W'(MAX_DEPTH - 1);

  generate
    if (OUT_W > FSEL_W + 2 * NODE_AW) begin : g_bad_out_w
      $error("dt_walk_engine: OUT_W does not fit in a node entry");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ENT_W-1:0]    r_table [N_NODES];
  logic [IN_W-1:0]     r_feat;
  logic [NODE_AW-1:0]  r_ptr;
  logic [DEPTH_W-1:0]  r_depth;
  logic [OUT_W-1:0]    r_out_data;
  logic                r_out_err;

  logic [ENT_W-1:0]    w_entry;
  logic                w_split;
  logic [FSEL_W-1:0]   w_sel;
  logic [NODE_AW-1:0]  w_child_t;
  logic [NODE_AW-1:0]  w_child_f;
  logic                w_sel_bad;
  logic                w_bit;
  logic                w_accept;
  logic                w_step;
  logic                w_leaf;
  logic                w_abort;

  assign w_entry   = r_table[r_ptr];
  assign w_split   = w_entry[ENT_W-1];
  assign w_sel     = w_entry[FSEL_W+2*NODE_AW-1:2*NODE_AW];
  assign w_child_t = w_entry[2*NODE_AW-1:NODE_AW];
  assign w_child_f = w_entry[NODE_AW-1:0];
  assign w_sel_bad = ({1'b0, w_sel} >= C_IN_W);

  // Out-of-range selects never reach the mux output; they abort the walk instead.
  always_comb begin
    w_bit = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (w_sel == FSEL_W'(i)) w_bit = r_feat[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_leaf      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~cfg_we & ~rst;
        if (in_valid && !cfg_we && !rst) begin
          w_accept    = 1'b1;
          w_state_nxt = WALK;
        end
      end
      WALK: begin
        if (!w_split) begin
          w_leaf      = 1'b1;
          w_state_nxt = DONE;
        end else if (w_sel_bad || (r_depth == C_DEPTH_LAST)) begin
          w_abort     = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Writes only land in IDLE so a walk always sees a frozen table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NODES; i++) r_table[i] <= '0;
    end else if (cfg_we && (r_state == IDLE)) begin
      r_table[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_feat     <= '0;
      r_ptr      <= '0;
      r_depth    <= '0;
      r_out_data <= '0;
      r_out_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_feat  <= in_data;
        r_ptr   <= '0;
        r_depth <= '0;
      end
      if (w_step) begin
        r_ptr   <= w_bit ? w_child_t : w_child_f;
        r_depth <= r_depth + 1'b1;
      end
      if (w_leaf) begin
        r_out_data <= w_entry[OUT_W-1:0];
        r_out_err  <= 1'b0;
      end
      if (w_abort) begin
        r_out_data <= '0;
        r_out_err  <= 1'b1;
      end
    end
  end

  assign out_data = r_out_data;
  assign out_err  = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_dt_walk_engine.sv
// ---------------------------------------------------------------------------
// tb_dt_walk_engine : directed + randomized bench with a tree-walk reference
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dt_walk_engine;

  localparam int IN_W      = 5;
  localparam int OUT_W     = 5;
  localparam int NODE_AW   = 4;
  localparam int MAX_DEPTH = 8;
  localparam int ENT_W     = 12;
  localparam int N_NODES   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [NODE_AW-1:0] cfg_addr = '0;
  logic [ENT_W-1:0]   cfg_wdata = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [IN_W-1:0]    in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [OUT_W-1:0]   out_data;
  logic               out_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [ENT_W-1:0] m_tbl [N_NODES];

  dt_walk_engine #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NODE_AW(NODE_AW), .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [ENT_W-1:0] split_e(input int sel, input int t, input int f);
    logic [2:0] s3 = 3'(sel);
    logic [3:0] t4 = 4'(t);
    logic [3:0] f4 = 4'(f);
    return {1'b1, s3, t4, f4};
  endfunction

  function automatic logic [ENT_W-1:0] leaf_e(input logic [4:0] v);
    return {7'b0, v};
  endfunction

  // Walk the tree from the root following the spec rules directly.
  function automatic void model(input logic [4:0] x, output logic [4:0] v,
                                output logic e, output int lat);
    int p = 0;
    v = '0; e = 1'b1; lat = MAX_DEPTH;
    for (int d = 0; d < MAX_DEPTH; d++) begin
      logic [ENT_W-1:0] ent = m_tbl[p];
      int sel = int'(ent[10:8]);
      if (!ent[11]) begin
        v = ent[4:0]; e = 1'b0; lat = d + 1; return;
      end
      if (sel >= IN_W || d == MAX_DEPTH - 1) begin
        v = '0; e = 1'b1; lat = d + 1; return;
      end
      p = x[sel] ? int'(ent[7:4]) : int'(ent[3:0]);
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cfg_write(input int addr, input logic [ENT_W-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_wdata = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    m_tbl[addr] = d;
  endtask

  task automatic start_vec(input logic [4:0] x, input string tag);
    @(negedge clk);
    in_valid = 1'b1; in_data = x;
    #1 check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_data = 5'($urandom);
    #1 check({tag, " in_ready walk"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_result(input logic [4:0] ev, input logic ee, input int elat, input string tag);
    int k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(elat));
    check({tag, " out_data"}, 32'(out_data), 32'(ev));
    check({tag, " out_err"}, 32'(out_err), 32'(ee));
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_model(input logic [4:0] x, input string tag);
    logic [4:0] v; logic e; int lat;
    model(x, v, e, lat);
    start_vec(x, tag);
    wait_result(v, e, lat, tag);
    ack(tag);
  endtask

  initial begin
    logic [4:0] x;
    logic       seen;
    for (int i = 0; i < N_NODES; i++) m_tbl[i] = '0;

    // reset
    @(negedge clk); @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    #1 check("post rst in_ready", 32'(in_ready), 32'd1);

    start_vec(5'b10101, "empty");
    wait_result(5'b00000, 1'b0, 1, "empty");
    ack("empty");

    // directed tree
    cfg_write(0, split_e(3, 1, 2));   cfg_write(1, split_e(1, 7, 8));
    cfg_write(2, split_e(1, 3, 4));   cfg_write(3, leaf_e(5'b00111));
    cfg_write(4, split_e(0, 5, 6));   cfg_write(5, split_e(4, 3, 6));
    cfg_write(6, leaf_e(5'b01111));   cfg_write(7, split_e(4, 10, 9));
    cfg_write(8, split_e(2, 9, 3));   cfg_write(9, leaf_e(5'b00011));
    cfg_write(10, split_e(0, 11, 12)); cfg_write(11, leaf_e(5'b00000));
    cfg_write(12, leaf_e(5'b00001));

    start_vec(5'b11011, "t11011"); wait_result(5'b00000, 1'b0, 5, "t11011"); ack("t11011");
    start_vec(5'b00000, "t00000"); wait_result(5'b01111, 1'b0, 4, "t00000"); ack("t00000");
    start_vec(5'b01010, "t01010"); wait_result(5'b00011, 1'b0, 4, "t01010"); ack("t01010");

    for (int i = 0; i < 16; i++) run_model(5'($urandom), "rand tree");

    // stall in DONE with a dropped config write
    start_vec(5'b11011, "stall");
    wait_result(5'b00000, 1'b0, 5, "stall");
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cfg_we = (i == 3); cfg_addr = 4'd11; cfg_wdata = leaf_e(5'b11111);
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 5'b00000 || out_err !== 1'b0 || in_ready !== 1'b0)
        seen = 1'b1;
    end
    cfg_we = 1'b0;
    check("stall hold stable", 32'(seen), 32'd0);
    ack("stall");
    start_vec(5'b11011, "rerun"); wait_result(5'b00000, 1'b0, 5, "rerun"); ack("rerun");

    // random tables, including cycles and bad selects
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N_NODES; i++) cfg_write(i, 12'($urandom));
      for (int i = 0; i < 8; i++) run_model(5'($urandom), "rand table");
    end

    cfg_write(0, split_e(0, 0, 0));
    x = 5'($urandom);
    start_vec(x, "self loop"); wait_result(5'b00000, 1'b1, 8, "self loop"); ack("self loop");
    cfg_write(0, split_e(7, 1, 2));
    start_vec(x, "bad sel"); wait_result(5'b00000, 1'b1, 1, "bad sel"); ack("bad sel");

    // cfg_we and in_valid collide in IDLE
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = leaf_e(5'b10110);
    in_valid = 1'b1; in_data = 5'b01100;
    #1 check("collide in_ready", 32'(in_ready), 32'd0);
    m_tbl[0] = leaf_e(5'b10110);
    @(negedge clk);
    cfg_we = 1'b0;
    #1 check("collide next in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(5'b10110, 1'b0, 1, "collide");
    ack("collide");

    // reset mid-walk
    cfg_write(0, split_e(0, 0, 0));
    start_vec(5'b10011, "rst walk");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N_NODES; i++) m_tbl[i] = '0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("rst walk no result", 32'(seen), 32'd0);
    run_model(5'($urandom), "after rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
